// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles every signal between mem_arbiter, its three requesters (loader,
// video, CPU) and the downstream SDRAM controller wrapper.
//   slave  : arbiter side (takes requests and mem_done/mem_dout, drives acks,
//            rdata, status and the memory strobes)
//   master : requester/memory side (the mirror image)
// Handshake: a requester holds req high with stable addr/data until it sees
// its one-cycle ack, and drops req on the clock edge that ends the ack cycle;
// req still high in the following cycle is a new request. Downstream, one
// mem_rd/mem_we strobe cycle is answered by one mem_done pulse no earlier than
// the cycle after the strobe; mem_dout is valid with mem_done.
// dbg_state exposes the arbiter FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE).
interface mem_arbiter_if #(
    parameter int AW = 25
);
    logic          ld_active;
    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_din;
    logic          ld_ack;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_ack;
    logic [7:0]    rdata;
    logic          busy;
    logic          err;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_rd;
    logic          mem_we;
    logic [7:0]    mem_dout;
    logic          mem_done;
    logic [1:0]    dbg_state;

    modport slave (
        input  ld_active, ld_req, ld_we, ld_addr, ld_din,
        input  vid_req, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        input  mem_dout, mem_done,
        output ld_ack, vid_ack, cpu_ack, rdata, busy, err,
        output mem_addr, mem_din, mem_rd, mem_we, dbg_state
    );

    modport master (
        output ld_active, ld_req, ld_we, ld_addr, ld_din,
        output vid_req, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        output mem_dout, mem_done,
        input  ld_ack, vid_ack, cpu_ack, rdata, busy, err,
        input  mem_addr, mem_din, mem_rd, mem_we, dbg_state
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Single-port memory arbiter between the SDRAM controller wrapper and three
// requesters: loader > video > CPU fixed priority, one access in flight at a
// time, with a WAIT timeout so a lost mem_done cannot hang a requester.
// Ports:
//   clk_sys  system clock, all logic on the rising edge
//   reset    synchronous, active-high
//   bus      mem_arbiter_if.slave (requester, memory and status signals)
// Parameters: AW address width, MAX_VID_BURST video grants allowed while the
// CPU waits (anti-starvation only), TIMEOUT WAIT cycles before a forced
// completion (8-bit counter).
// Optional feature macro: ARB_ANTISTARVE_EN -- after MAX_VID_BURST video grants
// made while the CPU was requesting, the next arbitration goes to the CPU.
// Without it priority is strict and the CPU can starve under constant video.
module mem_arbiter #(
    parameter int AW            = 25,
    parameter int MAX_VID_BURST = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic         clk_sys,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_LD   = 2'd1,
        G_VID  = 2'd2,
        G_CPU  = 2'd3
    } grant_t;

    state_t        state_q, state_d;
    grant_t        grant_q, win;
    logic [AW-1:0] addr_q, win_addr;
    logic [7:0]    din_q, win_din, rdata_q, cnt_q;
    logic          we_q, win_we, err_q;
    logic          vid_ok, cpu_ok, cpu_first, timed_out;

    // ld_active hands the whole memory to the loader.
    assign vid_ok    = bus.vid_req & ~bus.ld_active;
    assign cpu_ok    = bus.cpu_req & ~bus.ld_active;
    assign timed_out = (cnt_q == 8'(TIMEOUT));

`ifdef ARB_ANTISTARVE_EN
    localparam int VRW = $clog2(MAX_VID_BURST) + 1;
    logic [VRW-1:0] vid_run_q;

    // Counts video grants taken while the CPU was waiting; only moves in IDLE,
    // the only state where arbitration happens.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vid_run_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (!cpu_ok || win == G_CPU) begin
                vid_run_q <= '0;
            end else if (win == G_VID) begin
                vid_run_q <= vid_run_q + 1'b1;
            end
        end
    end

    assign cpu_first = cpu_ok && (vid_run_q == VRW'(MAX_VID_BURST));
`else
    assign cpu_first = 1'b0;
`endif

    // Arbitration winner; only consumed while in IDLE.
    always_comb begin
        win      = G_NONE;
        win_addr = '0;
        win_din  = '0;
        win_we   = 1'b0;
        if (bus.ld_req) begin
            win      = G_LD;
            win_addr = bus.ld_addr;
            win_din  = bus.ld_din;
            win_we   = bus.ld_we;
        end else if (cpu_first || (cpu_ok && !vid_ok)) begin
            win      = G_CPU;
            win_addr = bus.cpu_addr;
            win_din  = bus.cpu_din;
            win_we   = bus.cpu_we;
        end else if (vid_ok) begin
            win      = G_VID;
            win_addr = bus.vid_addr;
        end
    end

    // FSM state register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (win != G_NONE) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (bus.mem_done || timed_out) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Grant/address latch, timeout counter, read data and error flag.
    // mem_done is only looked at in WAIT, so stray or late pulses are ignored.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            grant_q <= G_NONE;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win != G_NONE) begin
                        grant_q <= win;
                        addr_q  <= win_addr;
                        din_q   <= win_din;
                        we_q    <= win_we;
                    end
                end
                ST_ISSUE: cnt_q <= '0;
                ST_WAIT: begin
                    if (bus.mem_done) begin
                        if (!we_q) rdata_q <= bus.mem_dout;
                    end else if (timed_out) begin
                        if (!we_q) rdata_q <= 8'hFF;
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_DONE: grant_q <= G_NONE;
                default: grant_q <= G_NONE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        bus.mem_rd  = (state_q == ST_ISSUE) && !we_q;
        bus.mem_we  = (state_q == ST_ISSUE) && we_q;
        bus.ld_ack  = (state_q == ST_DONE) && (grant_q == G_LD);
        bus.vid_ack = (state_q == ST_DONE) && (grant_q == G_VID);
        bus.cpu_ack = (state_q == ST_DONE) && (grant_q == G_CPU);
        bus.busy    = (state_q != ST_IDLE);
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = din_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter: a table of single-requester accesses with
// hand-computed ack cycles and read data, then hand-written sequences for
// reset values, simultaneous video/CPU requests, loader ownership, timeout,
// grant ordering under continuous video and CPU requests, and reset mid-access.
// Cycle numbering: cycle 0 is the IDLE cycle in which the request is presented,
// cycle 1 the strobe cycle, and so on.
module tb_mem_arbiter;
    localparam int AW = 25;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW)) bus ();

    mem_arbiter #(
        .AW(AW),
        .MAX_VID_BURST(4),
        .TIMEOUT(255)
    ) dut (
        .clk_sys(clk),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct {
        string         name;
        int            src;       // 1 loader, 2 video, 3 cpu
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    din;
        logic [7:0]    dout;      // memory read data returned with mem_done
        int            dly;       // mem_done this many cycles after the strobe
        int            exp_ack;   // cycle of the ack
        logic [7:0]    exp_rdata; // rdata during the ack cycle
    } vec_t;

    vec_t vecs[6];

    int n_checks = 0;
    int n_pass   = 0;

    // Per-sequence observations
    int            cyc, done_at, done_dly;
    logic [7:0]    auto_dout;
    bit            hold_reqs;
    bit            p_ld, p_vid, p_cpu;
    int            rd_n, wr_n, busy_n, err_n, err_cyc;
    int            st_cyc;
    logic [AW-1:0] st_addr;
    logic [7:0]    st_din;
    int            ack_total, ack_cyc, ack_src;
    logic [7:0]    ack_rdata;
    int            ld_ack_n, vid_ack_n, cpu_ack_n, vid_ack_cyc, cpu_ack_cyc;
    logic [7:0]    cpu_ack_rdata;
    logic [1:0]    exp_q[$];
    logic [1:0]    act_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_stats();
        cyc = 0; done_at = -1; hold_reqs = 1'b0;
        p_ld = 1'b0; p_vid = 1'b0; p_cpu = 1'b0;
        rd_n = 0; wr_n = 0; busy_n = 0; err_n = 0; err_cyc = -1;
        st_cyc = -1; st_addr = '0; st_din = '0;
        ack_total = 0; ack_cyc = -1; ack_src = 0; ack_rdata = '0;
        ld_ack_n = 0; vid_ack_n = 0; cpu_ack_n = 0;
        vid_ack_cyc = -1; cpu_ack_cyc = -1; cpu_ack_rdata = '0;
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.ld_active = 1'b0; bus.ld_req = 1'b0; bus.ld_we = 1'b0;
        bus.ld_addr = '0; bus.ld_din = '0;
        bus.vid_req = 1'b0; bus.vid_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
        bus.mem_done = 1'b0; bus.mem_dout = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic note_ack(input int src);
        ack_total++;
        if (ack_cyc < 0) begin
            ack_cyc   = cyc;
            ack_src   = src;
            ack_rdata = bus.rdata;
        end
        act_q.push_back(2'(src));
    endtask

    // One clock cycle: requesters drop req after their ack, the memory model
    // answers the strobe done_dly cycles later, then outputs are sampled.
    task automatic cycle_auto();
        @(posedge clk); #1;
        cyc++;
        if (!hold_reqs) begin
            if (p_ld)  bus.ld_req  = 1'b0;
            if (p_vid) bus.vid_req = 1'b0;
            if (p_cpu) bus.cpu_req = 1'b0;
        end
        bus.mem_done = (cyc == done_at);
        bus.mem_dout = (cyc == done_at) ? auto_dout : 8'h00;
        @(negedge clk);
        if (bus.mem_rd || bus.mem_we) begin
            if (bus.mem_rd) rd_n++;
            if (bus.mem_we) wr_n++;
            if (st_cyc < 0) begin
                st_cyc  = cyc;
                st_addr = bus.mem_addr;
                st_din  = bus.mem_din;
            end
            done_at = (done_dly > 0) ? cyc + done_dly : -1;
        end
        if (bus.busy) busy_n++;
        if (bus.err) begin
            err_n++;
            err_cyc = cyc;
        end
        if (bus.ld_ack) begin
            ld_ack_n++;
            note_ack(1);
        end
        if (bus.vid_ack) begin
            vid_ack_n++;
            if (vid_ack_cyc < 0) vid_ack_cyc = cyc;
            note_ack(2);
        end
        if (bus.cpu_ack) begin
            cpu_ack_n++;
            if (cpu_ack_cyc < 0) begin
                cpu_ack_cyc   = cyc;
                cpu_ack_rdata = bus.rdata;
            end
            note_ack(3);
        end
        p_ld  = bus.ld_ack;
        p_vid = bus.vid_ack;
        p_cpu = bus.cpu_ack;
    endtask

    initial begin
        bit antistarve;
`ifdef ARB_ANTISTARVE_EN
        antistarve = 1'b1;
`else
        antistarve = 1'b0;
`endif
        done_dly  = 1;
        auto_dout = 8'h00;

        //                name           src we    addr          din    dout   dly ack rdata
        vecs[0] = '{"cpu_rd",      3, 1'b0, 25'h0000123, 8'h00, 8'h5A, 1, 3, 8'h5A};
        vecs[1] = '{"cpu_wr",      3, 1'b1, 25'h0000456, 8'h3C, 8'hEE, 1, 3, 8'h5A};
        vecs[2] = '{"vid_rd",      2, 1'b0, 25'h01ABCDE, 8'h00, 8'hC3, 3, 5, 8'hC3};
        vecs[3] = '{"ld_wr",       1, 1'b1, 25'h0010000, 8'hA5, 8'hEE, 2, 4, 8'hC3};
        vecs[4] = '{"ld_rd_top",   1, 1'b0, 25'h1FFFFFF, 8'h00, 8'h00, 1, 3, 8'h00};
        vecs[5] = '{"cpu_rd_slow", 3, 1'b0, 25'h0000000, 8'h00, 8'h81, 5, 7, 8'h81};

        // Reset values
        do_reset();
        chk("rst_state", 32'(bus.dbg_state), 32'd0);
        chk("rst_ctrl", {bus.ld_ack, bus.vid_ack, bus.cpu_ack, bus.mem_rd, bus.mem_we, bus.busy, bus.err}, 7'd0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_din", bus.mem_din, 0);
        chk("rst_rdata", bus.rdata, 0);

        // Table of single-requester accesses (rdata carries across entries)
        for (int i = 0; i < 6; i++) begin
            clr_stats();
            done_dly  = vecs[i].dly;
            auto_dout = vecs[i].dout;
            case (vecs[i].src)
                1: begin
                    bus.ld_req = 1'b1; bus.ld_we = vecs[i].we;
                    bus.ld_addr = vecs[i].addr; bus.ld_din = vecs[i].din;
                end
                2: begin
                    bus.vid_req = 1'b1; bus.vid_addr = vecs[i].addr;
                end
                default: begin
                    bus.cpu_req = 1'b1; bus.cpu_we = vecs[i].we;
                    bus.cpu_addr = vecs[i].addr; bus.cpu_din = vecs[i].din;
                end
            endcase
            for (int c = 0; c < 20 && ack_total == 0; c++) cycle_auto();
            chk({vecs[i].name, "_strobe_cyc"}, st_cyc, 1);
            chk({vecs[i].name, "_wr_n"}, wr_n, vecs[i].we ? 1 : 0);
            chk({vecs[i].name, "_rd_n"}, rd_n, vecs[i].we ? 0 : 1);
            chk({vecs[i].name, "_addr"}, st_addr, vecs[i].addr);
            if (vecs[i].we) chk({vecs[i].name, "_din"}, st_din, vecs[i].din);
            chk({vecs[i].name, "_ack_cyc"}, ack_cyc, vecs[i].exp_ack);
            chk({vecs[i].name, "_ack_src"}, ack_src, vecs[i].src);
            chk({vecs[i].name, "_rdata"}, ack_rdata, vecs[i].exp_rdata);
            chk({vecs[i].name, "_busy_cycles"}, busy_n, vecs[i].exp_ack);
            chk({vecs[i].name, "_err"}, err_n, 0);
            cycle_auto();
            chk({vecs[i].name, "_idle_after"}, {bus.busy, bus.ld_ack, bus.vid_ack, bus.cpu_ack}, 4'd0);
        end

        // Video and CPU requesting in the same cycle: video first, CPU 4 cycles later
        do_reset();
        clr_stats();
        done_dly = 1; auto_dout = 8'h77;
        bus.vid_req = 1'b1; bus.vid_addr = 25'h0000100;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 25'h0000200;
        for (int c = 0; c < 12; c++) cycle_auto();
        chk("simul_vid_ack_cyc", vid_ack_cyc, 3);
        chk("simul_cpu_ack_cyc", cpu_ack_cyc, 7);
        chk("simul_cpu_rdata", cpu_ack_rdata, 8'h77);
        chk("simul_acks", {8'(vid_ack_n), 8'(cpu_ack_n)}, {8'd1, 8'd1});

        // Loader owns memory: CPU request masked until ld_active drops
        do_reset();
        clr_stats();
        done_dly = 1; auto_dout = 8'h11;
        bus.ld_active = 1'b1;
        bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 25'h0010000; bus.ld_din = 8'hA5;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 25'h0000222;
        for (int c = 0; c < 12; c++) cycle_auto();
        chk("ldact_wr_n", wr_n, 1);
        chk("ldact_rd_n", rd_n, 0);
        chk("ldact_addr", st_addr, 25'h0010000);
        chk("ldact_din", st_din, 8'hA5);
        chk("ldact_ld_ack_n", ld_ack_n, 1);
        chk("ldact_cpu_masked", cpu_ack_n, 0);
        bus.ld_active = 1'b0;
        bus.ld_we = 1'b0;
        for (int c = 0; c < 8; c++) cycle_auto();
        chk("ldact_cpu_after", cpu_ack_n, 1);
        chk("ldact_rd_after", rd_n, 1);

        // Timeout: no mem_done ever
        do_reset();
        clr_stats();
        done_dly = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 25'h00000AA;
        for (int c = 0; c < 300 && cpu_ack_n == 0; c++) cycle_auto();
        chk("tmo_acked", cpu_ack_n, 1);
        chk("tmo_latency", cpu_ack_cyc - st_cyc, 257);
        chk("tmo_rdata", cpu_ack_rdata, 8'hFF);
        chk("tmo_err_n", err_n, 1);
        chk("tmo_err_cyc", err_cyc, cpu_ack_cyc);
        cycle_auto();
        chk("tmo_err_pulse", err_n, 1);

        // Continuous video and CPU requests: grant order
        do_reset();
        clr_stats();
        done_dly = 1; auto_dout = 8'h22;
        hold_reqs = 1'b1;
        bus.vid_req = 1'b1; bus.vid_addr = 25'h0000300;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 25'h0000400;
        for (int i = 0; i < 6; i++) exp_q.push_back((antistarve && i == 4) ? 2'd3 : 2'd2);
        for (int c = 0; c < 24; c++) cycle_auto();
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b0;
        chk("order_len", act_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("order%0d", i), (i < act_q.size()) ? act_q[i] : 2'd0, exp_q[i]);
        end

        // Reset during WAIT, then a late mem_done
        do_reset();
        clr_stats();
        done_dly = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 25'h0000333;
        for (int c = 0; c < 3; c++) cycle_auto();
        chk("rstw_in_wait", 32'(bus.dbg_state), 32'd2);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.mem_done = 1'b1;
        bus.mem_dout = 8'hEE;
        @(negedge clk);
        chk("rstw_state", 32'(bus.dbg_state), 32'd0);
        chk("rstw_ctrl", {bus.ld_ack, bus.vid_ack, bus.cpu_ack, bus.mem_rd, bus.mem_we, bus.busy, bus.err}, 7'd0);
        chk("rstw_addr", bus.mem_addr, 0);
        chk("rstw_rdata", bus.rdata, 0);
        @(posedge clk); #1;
        bus.mem_done = 1'b0;
        bus.mem_dout = 8'h00;
        @(negedge clk);
        chk("rstw_late_done", {bus.cpu_ack, bus.busy, bus.err}, 3'd0);
        chk("rstw_rdata_kept", bus.rdata, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter placed between the SDRAM controller wrapper and its three requesters: the ROM/disk image loader, the video fetch engine and the CPU bus. It serialises accesses with a req/ack handshake, applies fixed priority (loader > video > CPU) with an optional CPU anti-starvation rule, and enforces a timeout so a missing completion never hangs the CPU.

## Interface
Parameters:
- AW, 25, address width (covers the loader address space)
- MAX_VID_BURST, 4, consecutive video grants allowed while CPU is pending (anti-starvation only)
- TIMEOUT, 255, WAIT-state cycles before forced completion (8-bit counter)

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- ld_active  in  1  loader owns memory; masks vid_req and cpu_req
- ld_req / ld_we  in  1 / 1  loader request, write select
- ld_addr / ld_din  in  AW / 8  loader address, write data
- ld_ack  out  1  loader completion pulse
- vid_req  in  1  video read request (read-only)
- vid_addr  in  AW  video address
- vid_ack  out  1  video completion pulse
- cpu_req / cpu_we  in  1 / 1  CPU request, write select
- cpu_addr / cpu_din  in  AW / 8  CPU address, write data
- cpu_ack  out  1  CPU completion pulse
- rdata  out  8  read data, valid in the ack cycle; holds until next ack
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse on timeout completion
- mem_addr / mem_din  out  AW / 8  downstream address, write data
- mem_rd / mem_we  out  1 / 1  one-cycle access strobes
- mem_dout  in  8  downstream read data, valid with mem_done
- mem_done  in  1  downstream completion pulse

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: evaluate requests; winner latched into grant register with its addr/din/we; go ISSUE. No request: stay IDLE.
- Priority: ld_req > vid_req > cpu_req. ld_active=1 forces vid_req and cpu_req to be treated as 0.
- ISSUE: mem_rd=~we or mem_we=we for exactly one cycle; mem_addr/mem_din driven from latched values and held through DONE; go WAIT, timeout counter cleared.
- WAIT: on mem_done, capture mem_dout into rdata (reads only; writes leave rdata unchanged), go DONE. Counter increments each cycle; when counter reaches TIMEOUT without mem_done: rdata=8'hFF for reads, err pulse, go DONE.
- DONE: granted requester's ack=1 for one cycle; go IDLE.
- Requester rule: req level-held with stable addr/data until ack; requester drops req on the edge ending its ack cycle; req still high in the following IDLE cycle is a new request.
- mem_done outside WAIT is ignored.

## Timing
- Reset values: state IDLE, all acks 0, mem_rd/mem_we 0, mem_addr 0, mem_din 0, rdata 0, busy 0, err 0, grant none, counters 0.
- Reset mid-access: next cycle IDLE, strobes low, no ack issued, late mem_done ignored.
- Minimum latency: req sampled in IDLE cycle 0, strobe cycle 1, mem_done earliest cycle 2, ack cycle 3; next arbitration cycle 4. Peak throughput one access per 4 cycles.
- Timeout: mem_done absent for TIMEOUT WAIT cycles gives ack TIMEOUT+2 cycles after strobe, err coincident with DONE entry.
- Simultaneous requests resolved only in IDLE; requests arriving during a busy access wait, never preempt.
- Downstream guarantees mem_done no earlier than the cycle after the strobe.

## Configuration
- ARB_ANTISTARVE_EN defined: counter vid_run (width clog2(MAX_VID_BURST)+1) increments on each video grant made while cpu_req=1; when vid_run==MAX_VID_BURST and cpu_req=1 (ld_active=0), the next IDLE arbitration grants CPU over video. vid_run clears on CPU grant, when cpu_req=0 in IDLE, and on reset. Loader priority unaffected.
- Not defined: strict priority ld > vid > cpu; CPU may starve indefinitely under continuous vid_req.

## Test plan
- Single CPU read addr 0x0123, mem_done 1 cycle after strobe, mem_dout 0x5A -> mem_rd pulse cycle 1, cpu_ack cycle 3, rdata=0x5A, busy high cycles 1-3.
- vid_req and cpu_req asserted same cycle, both reads -> vid_ack first, cpu_ack 4 cycles later (mem_done min latency).
- ld_active=1, ld_req write 0xA5 to 0x1_0000 with cpu_req pending -> mem_we once, ld_ack, cpu never granted until ld_active=0.
- CPU read with mem_done never asserted, TIMEOUT=255 -> cpu_ack at 257 cycles after strobe, rdata=0xFF, err one-cycle pulse.
- With ARB_ANTISTARVE_EN, MAX_VID_BURST=4, vid_req and cpu_req held high -> grant order V,V,V,V,C,V,...; without macro -> CPU never granted.
- Reset asserted in WAIT then mem_done arrives -> no ack, state IDLE, outputs at reset values.
